// File: rtl/mul_unit_seq.sv
// mul_unit_seq
// Iterative shift-add multiplier for the EXE stage. One partial product is
// accumulated per cycle, so a WORD_LEN x WORD_LEN multiply takes WORD_LEN
// iterations. While it works, the pipeline is held through stall. When the
// product is ready, it is presented on {hi, lo} together with a one-cycle
// is_mul write-back strobe. The register file writes lo to R13 and hi to R12.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      multiply request, honoured only in IDLE
//   is_signed  1 = two's-complement operands, sampled with start
//   op_a       multiplicand, sampled with start
//   op_b       multiplier, sampled with start
//   flush      synchronous abort; back to IDLE with no write-back
//   stall      high while a product is pending (combinational)
//   is_mul     one-cycle write-back strobe (DONE state)
//   lo         low half of the registered product
//   hi         high half of the registered product
module mul_unit_seq #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_signed,
    input  logic [WORD_LEN-1:0] op_a,
    input  logic [WORD_LEN-1:0] op_b,
    input  logic                flush,
    output logic                stall,
    output logic                is_mul,
    output logic [WORD_LEN-1:0] lo,
    output logic [WORD_LEN-1:0] hi
);

    localparam int CW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam int PW = 2 * WORD_LEN;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WORD_LEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       mcand_q, mcand_d;
    logic [WORD_LEN-1:0] mplr_q, mplr_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic                neg_q, neg_d;
    logic [WORD_LEN-1:0] lo_q, lo_d;
    logic [WORD_LEN-1:0] hi_q, hi_d;

    logic [WORD_LEN-1:0] mag_a;
    logic [WORD_LEN-1:0] mag_b;
    logic [PW-1:0]       acc_next;
    logic [PW-1:0]       product;

    // The iteration runs on magnitudes, and the sign is restored once at the
    // end. Negating 0x8000... gives 0x8000... again, which is the correct
    // unsigned magnitude 2^(W-1).
    assign mag_a = (is_signed && op_a[WORD_LEN-1]) ? -op_a : op_a;
    assign mag_b = (is_signed && op_b[WORD_LEN-1]) ? -op_b : op_b;

    // mcand_q is shifted left once per iteration. This gives the same result
    // as adding mcand << count, without needing a barrel shifter.
    assign acc_next = acc_q + (mplr_q[0] ? mcand_q : '0);
    assign product  = neg_q ? -acc_next : acc_next;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        lo_d    = lo_q;
        hi_d    = hi_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mcand_d = {{WORD_LEN{1'b0}}, mag_a};
                        mplr_d  = mag_b;
                        neg_d   = is_signed & (op_a[WORD_LEN-1] ^ op_b[WORD_LEN-1]);
                        acc_d   = '0;
                        count_d = '0;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_d   = acc_next;
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_q >> 1;
                    count_d = count_q + CW'(1);
                    // The final sum is folded in here, so the result is already
                    // on hi/lo during the DONE cycle when is_mul is high.
                    if (count_q == LAST_COUNT) begin
                        state_d      = ST_DONE;
                        {hi_d, lo_d} = product;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // A flush that arrives during DONE also suppresses the strobe, so a
    // squashed instruction never writes back.
    assign is_mul = (state_q == ST_DONE) & ~flush;

    // stall is combinational, so the issuing instruction is held in the same
    // cycle. It is forced low while the block is held in reset.
    assign stall = rst & ((start & (state_q == ST_IDLE)) |
                          (state_q == ST_BUSY) | (state_q == ST_DONE));

    assign lo = lo_q;
    assign hi = hi_q;

endmodule

// File: tb/tb_mul_unit_seq.sv
// tb_mul_unit_seq
// Self-checking bench for mul_unit_seq (WORD_LEN = 32). The expected products
// are computed with plain 64-bit arithmetic. The expected timing is taken
// directly from the latency rule: the strobe appears WORD_LEN edges after the
// edge that samples start.
module tb_mul_unit_seq;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic          is_signed;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          flush;
    logic          stall;
    logic          is_mul;
    logic [W-1:0]  lo;
    logic [W-1:0]  hi;

    int            check_count = 0;
    int            fail_count  = 0;
    logic [2*W-1:0] last_result = '0;

    mul_unit_seq #(.WORD_LEN(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_signed(is_signed),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .stall    (stall),
        .is_mul   (is_mul),
        .lo       (lo),
        .hi       (hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sgn);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Issues one multiply and follows it for a fixed window of edges.
    // The optional events are given as edge offsets after the start-sampling
    // edge (-1 = unused):
    //   inj_k: a second start with operands 5 x 5
    //   fl_k:  a one-cycle flush
    //   rs_k:  an asynchronous reset pulse
    task automatic applyStimulus(input string name, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic sgn,
                                 input int inj_k, input int fl_k, input int rs_k);
        logic [63:0] expected;
        int          strobes;
        int          strobe_k;
        logic [63:0] strobe_val;
        bit          aborted;

        aborted  = (fl_k >= 0) || (rs_k >= 0);
        expected = refProduct(a, b, sgn);
        strobes  = 0;
        strobe_k = -1;
        strobe_val = '0;

        start     = 1'b1;
        is_signed = sgn;
        op_a      = a;
        op_b      = b;
        @(negedge clk);
        checkOutput({name, ".stall_on_start"}, 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;

        for (int k = 0; k <= W + 6; k++) begin
            if (k == inj_k) begin
                start = 1'b1;
                op_a  = 32'd5;
                op_b  = 32'd5;
            end else if (k == inj_k + 1) begin
                start = 1'b0;
            end
            if (k == fl_k) flush = 1'b1;
            else           flush = 1'b0;
            if (k == rs_k) begin
                rst = 1'b0;
                #1;
                checkOutput({name, ".rst_is_mul"}, 64'(is_mul), 64'd0);
                checkOutput({name, ".rst_stall"}, 64'(stall), 64'd0);
                checkOutput({name, ".rst_prod"}, {hi, lo}, 64'd0);
                last_result = '0;
            end else if (k == rs_k + 2) begin
                rst = 1'b1;
            end
            @(negedge clk);
            if (is_mul) begin
                strobes++;
                if (strobe_k < 0) begin
                    strobe_k   = k;
                    strobe_val = {hi, lo};
                end
            end
            if (!aborted && k == W / 2)
                checkOutput({name, ".stall_busy"}, 64'(stall), 64'd1);
            if (fl_k >= 0 && k == fl_k + 1)
                checkOutput({name, ".stall_after_flush"}, 64'(stall), 64'd0);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;

        if (aborted) begin
            checkOutput({name, ".no_strobe"}, 64'(strobes), 64'd0);
            checkOutput({name, ".prod_held"}, {hi, lo}, last_result);
        end else begin
            checkOutput({name, ".strobe_count"}, 64'(strobes), 64'd1);
            checkOutput({name, ".latency"}, 64'(strobe_k), 64'(W));
            checkOutput({name, ".prod_at_strobe"}, strobe_val, expected);
            checkOutput({name, ".prod_held"}, {hi, lo}, expected);
            checkOutput({name, ".stall_idle"}, 64'(stall), 64'd0);
            last_result = expected;
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rsg;

        rst       = 1'b0;
        start     = 1'b1;
        is_signed = 1'b0;
        op_a      = '0;
        op_b      = '0;
        flush     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.stall", 64'(stall), 64'd0);
        checkOutput("reset.is_mul", 64'(is_mul), 64'd0);
        checkOutput("reset.prod", {hi, lo}, 64'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, -1, -1);
        checkOutput("umax.hi", 64'(hi), 64'hFFFFFFFE);
        checkOutput("umax.lo", 64'(lo), 64'h00000001);
        applyStimulus("sneg3x7", 32'hFFFFFFFD, 32'd7, 1'b1, -1, -1, -1);
        checkOutput("sneg3x7.lo", 64'(lo), 64'hFFFFFFEB);
        applyStimulus("smin2", 32'h80000000, 32'h80000000, 1'b1, -1, -1, -1);
        checkOutput("smin2.hi", 64'(hi), 64'h40000000);
        applyStimulus("zero", 32'd0, 32'h12345678, 1'b0, -1, -1, -1);
        applyStimulus("ident", 32'd1, 32'h89ABCDEF, 1'b0, -1, -1, -1);
        applyStimulus("busy_start", 32'h00012345, 32'h00000777, 1'b0, 5, -1, -1);
        applyStimulus("flush", 32'hDEADBEEF, 32'h0000CAFE, 1'b1, -1, 20, -1);
        applyStimulus("after_flush", 32'hFFFFFFFF, 32'd2, 1'b1, -1, -1, -1);
        applyStimulus("reset_busy", 32'h11111111, 32'h22222222, 1'b0, -1, -1, 10);
        applyStimulus("after_reset", 32'd3, 32'd9, 1'b0, -1, -1, -1);

        for (int i = 0; i < 16; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rsg = 1'($urandom_range(0, 1));
            if (i % 5 == 0) ra = {1'b1, 31'($urandom_range(0, 3))};
            applyStimulus("random", ra, rb, rsg, -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
